// File: rtl/result_byte_scanner.sv
// Captures a 128-bit result word on load, flags whether it equals the expected
// word, then cycles its 16 bytes onto byte_out with a programmable dwell per byte.
module result_byte_scanner #(
  parameter int unsigned DWELL = 50_000_000,
  parameter int unsigned CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] data_in,
  input  logic [127:0] expected,
  input  logic         hold,
  output logic [7:0]   byte_out,
  output logic [3:0]   byte_idx,
  output logic         busy,
  output logic         match,
  output logic         wrap
);

  // state   | meaning
  // S_IDLE  | nothing captured since reset; outputs quiet
  // S_SCAN  | cycling through the captured word, byte 0 first
  typedef enum logic {S_IDLE, S_SCAN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_t             state_q, state_d;
  logic [127:0]       cap_q, cap_d;
  logic               match_q, match_d;
  logic [3:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [7:0]         byte_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      match_q <= match_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  // Load takes priority over both dwell expiry and hold.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    match_d = match_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (load) begin
      state_d = S_SCAN;
      cap_d   = data_in;
      match_d = (data_in == expected);
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_SCAN && !hold) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        idx_d  = idx_q + 4'd1;
        wrap_d = (idx_q == 4'd15);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Byte 0 lives in the most significant byte of the captured word.
  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (idx_q == 4'(i)) byte_sel = cap_q[127-8*i -: 8];
    end
  end

  assign busy     = (state_q == S_SCAN);
  assign byte_out = busy ? byte_sel : 8'h00;
  assign byte_idx = idx_q;
  assign match    = match_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_result_byte_scanner.sv
// Randomized and directed bench for result_byte_scanner; a model based on
// elapsed unheld cycles since load predicts every output each cycle.
module tb_result_byte_scanner;

  localparam int DW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [127:0] data_in;
  logic [127:0] expected;
  logic         hold;
  logic [7:0]   byte_out;
  logic [3:0]   byte_idx;
  logic         busy;
  logic         match;
  logic         wrap;

  int total = 0;
  int bad   = 0;

  // reference model: captured word, match flag, unheld cycles since load
  logic [127:0] m_word;
  logic         m_busy;
  logic         m_match;
  logic         m_wrap;
  int           m_t;

  result_byte_scanner #(.DWELL(DW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .expected(expected), .hold(hold), .byte_out(byte_out),
    .byte_idx(byte_idx), .busy(busy), .match(match), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_word = '0; m_busy = 1'b0; m_match = 1'b0; m_wrap = 1'b0; m_t = 0;
  endtask

  task automatic model_edge(input logic ld, input logic hd, input logic [127:0] d, input logic [127:0] e);
    if (!reset) begin
      model_reset();
    end else if (ld) begin
      m_word = d; m_match = (d == e); m_busy = 1'b1; m_t = 0; m_wrap = 1'b0;
    end else if (m_busy && !hd) begin
      m_t++;
      m_wrap = (m_t % (16*DW) == 0);
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic check_all(input string where);
    int    idx;
    logic [127:0] sh;
    idx = (m_t / DW) % 16;
    sh  = m_word >> (8*(15-idx));
    chk({where, ".busy"},  busy,     m_busy);
    chk({where, ".match"}, match,    m_match);
    chk({where, ".wrap"},  wrap,     m_wrap);
    chk({where, ".idx"},   byte_idx, m_busy ? idx : 0);
    chk({where, ".byte"},  byte_out, m_busy ? sh[7:0] : 8'h00);
  endtask

  task automatic cycle(input string where, input logic ld, input logic hd,
                       input logic [127:0] d, input logic [127:0] e);
    load = ld; hold = hd; data_in = d; expected = e;
    @(posedge clk);
    model_edge(ld, hd, d, e);
    #1;
    check_all(where);
    load = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] W0 = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] w, e;
    load = 0; hold = 0; data_in = '0; expected = '0;
    reset = 1'b0;
    model_reset();

    // reset / idle
    for (int i = 0; i < 3; i++) cycle("rst", 1'b0, i[0], rnd128(), rnd128());
    #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) cycle("idle", 1'b0, i[0], rnd128(), rnd128());

    // basic scan with equal expected, through one full wrap
    cycle("basic_ld", 1'b1, 1'b0, W0, W0);
    for (int i = 0; i < 70; i++) cycle("basic", 1'b0, 1'b0, rnd128(), rnd128());

    // mismatch on bit 0
    cycle("mis_ld", 1'b1, 1'b0, W0, W0 ^ 128'h1);
    for (int i = 0; i < 20; i++) cycle("mis", 1'b0, 1'b0, rnd128(), rnd128());

    // hold mid byte 3
    cycle("hold_ld", 1'b1, 1'b0, W0, W0);
    for (int i = 0; i < 13; i++) cycle("hold_pre", 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      cycle("hold_on", 1'b0, 1'b1, '0, '0);
      chk("hold_idx3", byte_idx, 4'd3);
    end
    cycle("hold_rel", 1'b0, 1'b0, '0, '0);
    chk("hold_byte3_still", byte_idx, 4'd3);
    for (int i = 0; i < 2; i++) cycle("hold_post", 1'b0, 1'b0, '0, '0);
    chk("hold_byte4", byte_idx, 4'd4);

    // load exactly on dwell expiry at index 15
    cycle("exp_ld", 1'b1, 1'b0, W0, W0);
    for (int i = 0; i < 16*DW - 1; i++) cycle("exp_run", 1'b0, 1'b0, '0, '0);
    chk("exp_at15", byte_idx, 4'd15);
    w = rnd128();
    cycle("exp_reload", 1'b1, 1'b0, w, w);
    chk("exp_nowrap", wrap, 1'b0);
    chk("exp_idx0", byte_idx, 4'd0);
    chk("exp_byte0", byte_out, w[127:120]);
    for (int i = 0; i < 5; i++) cycle("exp_post", 1'b0, 1'b0, '0, '0);

    // load while hold is high
    for (int i = 0; i < 9; i++) cycle("lh_pre", 1'b0, 1'b0, '0, '0);
    w = rnd128();
    cycle("lh_ld", 1'b1, 1'b1, w, ~w);
    for (int i = 0; i < 3; i++) cycle("lh_hold", 1'b0, 1'b1, '0, '0);
    chk("lh_idx0", byte_idx, 4'd0);
    for (int i = 0; i < 5; i++) cycle("lh_post", 1'b0, 1'b0, '0, '0);

    // async reset at index 7, between edges
    cycle("ar_ld", 1'b1, 1'b0, W0, W0);
    for (int i = 0; i < 7*DW; i++) cycle("ar_run", 1'b0, 1'b0, '0, '0);
    chk("ar_at7", byte_idx, 4'd7);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("ar_now");
    cycle("ar_low", 1'b0, 1'b0, W0, W0);
    #2 reset = 1'b1;
    for (int i = 0; i < 8; i++) cycle("ar_idle", 1'b0, i[1], rnd128(), rnd128());

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      w = rnd128();
      e = ($urandom_range(0, 1) != 0) ? w : (w ^ (128'h1 << $urandom_range(0, 127)));
      cycle("rnd", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0), w, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_byte_scanner.md
# result_byte_scanner

Downstream display stage for the cipher datapath. Captures one 128-bit result word (encrypt or decrypt output) on a load strobe, compares it against an expected word, then presents the captured word one byte at a time on an 8-bit output. The output feeds the existing bin2bcd / segment7 chain. Each byte is held for a programmable dwell time, and the scan cycles continuously through all 16 bytes.

## Interface
- `DWELL`, default 50_000_000: clock cycles each byte is shown. Legal range 1 to 2^32-1.
- `CNT_W`, default 32: dwell counter width. Must satisfy 2^CNT_W > DWELL.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); clears all state immediately, independent of `clk`.
- `load`  in  1  one-cycle capture strobe, sampled on the rising edge of `clk`.
- `data_in`  in  128  word to capture. Byte 0 = `data_in[127:120]`, byte 15 = `data_in[7:0]`.
- `expected`  in  128  reference word, compared against `data_in` at capture.
- `hold`  in  1  level; freezes the dwell counter and byte index while 1.
- `byte_out`  out  8  currently displayed byte of the captured word.
- `byte_idx`  out  4  index (0–15) of the displayed byte.
- `busy`  out  1  1 while scanning a captured word.
- `match`  out  1  1 if `data_in == expected` at the last capture.
- `wrap`  out  1  one-cycle pulse when the index wraps from 15 to 0.

## Operation
- Two states:
  - IDLE: entered on reset; nothing captured.
  - SCAN.
- IDLE behaviour: `busy` = 0 and `byte_out` = 0x00. `hold` has no effect. Only `load` exits IDLE.
- Load (in any state) performs, in one edge:
  - capture register <= `data_in`;
  - `match` <= (`data_in == expected`), full 128-bit compare;
  - index <= 0; dwell counter <= 0; state <= SCAN.
- Load during SCAN restarts cleanly: the new word is shown from byte 0. The previous word and its partial scan are discarded.
- SCAN behaviour:
  - The dwell counter increments each cycle while `hold` = 0.
  - When the counter equals DWELL-1 with `hold` = 0: counter <= 0 and index <= index+1 (mod 16).
  - On the 15→0 step, `wrap` = 1 for exactly that following cycle.
- `hold` = 1: counter and index keep their values and `wrap` stays 0. Scanning resumes exactly where it stopped when `hold` returns to 0.
- `byte_out` = capture[127-8*idx -: 8], derived only from registered state (no path from any input).
- Simultaneous events:
  - `load` with a dwell expiry: load wins; index = 0 and no `wrap` pulse.
  - `load` with `hold`: load wins; counter and index are cleared. Hold then applies from the next cycle.
- SCAN never returns to IDLE except through reset.
- DWELL = 1: the index advances every unheld cycle, and `wrap` fires every 16 unheld cycles.

## Timing
- Reset asserted (async): `byte_out` = 0x00, `byte_idx` = 0, `busy` = 0, `match` = 0, `wrap` = 0, state IDLE, capture register = 0, counter = 0.
- Reset released: the first active edge is the next rising `clk`. Reset during SCAN aborts the scan; a new `load` is required.
- Load latency: `load` high at edge N gives `busy` = 1, `byte_idx` = 0, `byte_out` = `data_in[127:120]` (value at edge N) and `match` valid, all after edge N.
- With no hold, byte k (k = 0..15) is shown for exactly DWELL cycles.
- The first index step occurs at edge N+DWELL. `wrap` is high during the cycle after edge N+16·DWELL.
- `data_in` and `expected` are sampled only on load edges. Changes between loads do not affect outputs.
- All outputs are registered or decoded from registers; there are no combinational input-to-output paths.

## Test plan
- Reset/idle: hold `reset` = 0 for 3 cycles, toggle `hold` -> all outputs 0 and stay 0 after release with no `load`.
- Basic scan (DWELL = 4): load `data_in` = 0x00112233445566778899aabbccddeeff with `expected` equal -> `match` = 1, `busy` = 1, `byte_out` sequence 0x00, 0x11, …, 0xff with each byte held 4 cycles. `wrap` pulses once after the 64th cycle, then 0x00 reappears.
- Mismatch: `expected` = the `data_in` value from the basic-scan case with bit 0 flipped -> `match` = 0; scan proceeds normally.
- Hold (DWELL = 4): assert `hold` for 10 cycles mid-byte 3 -> `byte_idx` stays 3, the counter resumes from its frozen value, and byte 3 totals 4 unheld cycles.
- Reload collisions: pulse `load` with a new word exactly on a dwell expiry at index 15 -> `byte_idx` = 0, new byte 0 shown, no `wrap` pulse. Also pulse `load` while `hold` = 1 -> index and counter are cleared.
- Async reset mid-scan: drive `reset` low between clock edges at index 7 -> outputs clear immediately without a clock edge, and the block stays idle until the next `load`.
